// File: rtl/roi_threshold_binarizer.sv
// Multi-band, ROI-gated pixel binarizer for the mocap front end.
// Two-stage pipeline in the pixelClock domain: stage 1 registers the pixel
// and its X/Y coordinates, and stage 2 registers the band/ROI decision.
// Configuration is double-buffered and commits at frame start. The
// binMask[0] population count of each frame is published at frame end.

// One threshold band: shadow/active low-high pair plus the inclusive compare.
module roi_threshold_band #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  pixelClock,
    input  logic                  reset,
    input  logic                  wrEn,
    input  logic [DATA_WIDTH-1:0] wrLow,
    input  logic [DATA_WIDTH-1:0] wrHigh,
    input  logic                  commit,
    input  logic [DATA_WIDTH-1:0] pixel,
    output logic                  hit
);

    logic [DATA_WIDTH-1:0] lowSh;
    logic [DATA_WIDTH-1:0] highSh;
    logic [DATA_WIDTH-1:0] lowAct;
    logic [DATA_WIDTH-1:0] highAct;

    // Shadow pair: written at any time. All-ones lets only saturated pixels pass.
    always_ff @(posedge pixelClock or negedge reset) begin
        if (!reset) begin
            lowSh  <= '1;
            highSh <= '1;
        end else if (wrEn) begin
            lowSh  <= wrLow;
            highSh <= wrHigh;
        end
    end

    // Active pair: loaded from the shadow only at frame start.
    always_ff @(posedge pixelClock or negedge reset) begin
        if (!reset) begin
            lowAct  <= '1;
            highAct <= '1;
        end else if (commit) begin
            lowAct  <= lowSh;
            highAct <= highSh;
        end
    end

    // An inverted band (low > high) can never satisfy both bounds.
    assign hit = (pixel >= lowAct) && (pixel <= highAct);

endmodule

module roi_threshold_binarizer #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_CHANNELS = 2,
    parameter int IMAGE_WIDTH  = 1280,
    parameter int IMAGE_HEIGHT = 800,
    parameter int NUM_BITS_X   = $clog2(IMAGE_WIDTH),
    parameter int NUM_BITS_Y   = $clog2(IMAGE_HEIGHT)
) (
    input  logic                             pixelClock,
    input  logic                             reset,
    input  logic                             href,
    input  logic                             vsync,
    input  logic [DATA_WIDTH-1:0]            camData,
    input  logic                             cfgWrite,
    input  logic [3:0]                       cfgAddr,
    input  logic [31:0]                      cfgData,
    output logic                             cfgPending,
    output logic                             hrefBin,
    output logic                             vsyncBin,
    output logic [NUM_CHANNELS-1:0]          binMask,
    output logic [NUM_BITS_X-1:0]            pixelX,
    output logic [NUM_BITS_Y-1:0]            pixelY,
    output logic [NUM_BITS_X+NUM_BITS_Y-1:0] frameOnes,
    output logic                             frameStatsValid
);

    localparam int NUM_BITS_S = NUM_BITS_X + NUM_BITS_Y;
    localparam logic [NUM_BITS_X-1:0] X_MAX = NUM_BITS_X'(IMAGE_WIDTH - 1);
    localparam logic [NUM_BITS_Y-1:0] Y_MAX = NUM_BITS_Y'(IMAGE_HEIGHT - 1);

    // ROI range in cfgData layout: end in the upper half, start in the lower.
    typedef struct packed {
        logic [15:0] stop;
        logic [15:0] start;
    } roiRange_t;

    localparam roiRange_t ROI_X_RST = '{stop: 16'(IMAGE_WIDTH - 1), start: 16'd0};
    localparam roiRange_t ROI_Y_RST = '{stop: 16'(IMAGE_HEIGHT - 1), start: 16'd0};

    // Stage 1
    logic [DATA_WIDTH-1:0] dataS1;
    logic                  hrefS1;
    logic                  vsyncS1;
    logic                  outS1;
    logic [NUM_BITS_X-1:0] xS1;
    logic [NUM_BITS_Y-1:0] yS1;
    logic                  pvS1;

    // Coordinate counters: coordinate the next valid pixel will receive
    logic [NUM_BITS_X-1:0] xCount;
    logic [NUM_BITS_Y-1:0] yCount;

    // Frame tracking
    logic blankSeen;
    logic frameSeen;
    logic pv;
    logic hrefFall;
    logic vsyncRise;

    // Configuration
    logic [NUM_CHANNELS-1:0] bandWr;
    logic [NUM_CHANNELS-1:0] bandHit;
    logic                    roiXWr;
    logic                    roiYWr;
    logic                    cfgAccept;
    roiRange_t               roiXSh;
    roiRange_t               roiYSh;
    roiRange_t               roiXAct;
    roiRange_t               roiYAct;

    // Decision and statistics
    logic                    xIn;
    logic                    yIn;
    logic                    pixelOk;
    logic [NUM_CHANNELS-1:0] maskNext;
    logic [NUM_BITS_S-1:0]   onesCount;
    logic [NUM_BITS_S-1:0]   onesNext;
    logic                    statsFire;

    assign pv       = href & vsync;
    assign pvS1     = hrefS1 & vsyncS1;
    assign hrefFall = hrefS1 & ~href;
    // A rise only counts after blanking has been observed since reset, so a
    // reset released mid-frame cannot fake a frame start.
    assign vsyncRise = vsync & ~vsyncS1 & blankSeen;

    // Stage-1 capture of the pixel, the sync lines and the pixel's coordinates.
    always_ff @(posedge pixelClock or negedge reset) begin
        if (!reset) begin
            dataS1  <= '0;
            hrefS1  <= 1'b0;
            vsyncS1 <= 1'b0;
            xS1     <= '0;
            yS1     <= '0;
            outS1   <= 1'b0;
        end else begin
            dataS1  <= camData;
            hrefS1  <= href;
            vsyncS1 <= vsync;
            if (pv) begin
                xS1   <= xCount;
                yS1   <= yCount;
                // Every pixel that arrives once X has reached its ceiling is
                // treated as lying outside the ROI.
                outS1 <= (xCount == X_MAX);
            end
        end
    end

    // X counter: advances per valid pixel, saturates, clears at end of line.
    always_ff @(posedge pixelClock or negedge reset) begin
        if (!reset) begin
            xCount <= '0;
        end else if (hrefFall) begin
            xCount <= '0;
        end else if (pv && xCount != X_MAX) begin
            xCount <= xCount + NUM_BITS_X'(1);
        end
    end

    // Y counter: advances per completed line, saturates, cleared in blanking.
    always_ff @(posedge pixelClock or negedge reset) begin
        if (!reset) begin
            yCount <= '0;
        end else if (!vsync) begin
            yCount <= '0;
        end else if (hrefFall && yCount != Y_MAX) begin
            yCount <= yCount + NUM_BITS_Y'(1);
        end
    end

    // Frame qualification: no mask output until a genuine frame start after reset.
    always_ff @(posedge pixelClock or negedge reset) begin
        if (!reset) begin
            blankSeen <= 1'b0;
            frameSeen <= 1'b0;
        end else begin
            if (!vsync)
                blankSeen <= 1'b1;
            if (vsyncRise)
                frameSeen <= 1'b1;
        end
    end

    // Per-channel bands, each with its own shadow/active pair.
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : gBand
        assign bandWr[c] = cfgWrite && (cfgAddr == 4'(c));

        roi_threshold_band #(
            .DATA_WIDTH(DATA_WIDTH)
        ) uBand (
            .pixelClock(pixelClock),
            .reset     (reset),
            .wrEn      (bandWr[c]),
            .wrLow     (cfgData[DATA_WIDTH-1:0]),
            .wrHigh    (cfgData[16 +: DATA_WIDTH]),
            .commit    (vsyncRise),
            .pixel     (dataS1),
            .hit       (bandHit[c])
        );
    end

    assign roiXWr    = cfgWrite && (cfgAddr == 4'd8);
    assign roiYWr    = cfgWrite && (cfgAddr == 4'd9);
    assign cfgAccept = (|bandWr) | roiXWr | roiYWr;

    // ROI shadow registers.
    always_ff @(posedge pixelClock or negedge reset) begin
        if (!reset) begin
            roiXSh <= ROI_X_RST;
            roiYSh <= ROI_Y_RST;
        end else begin
            if (roiXWr)
                roiXSh <= cfgData;
            if (roiYWr)
                roiYSh <= cfgData;
        end
    end

    // ROI active registers: the commit takes the pre-write shadow, so a write
    // coinciding with frame start is held for the following frame.
    always_ff @(posedge pixelClock or negedge reset) begin
        if (!reset) begin
            roiXAct <= ROI_X_RST;
            roiYAct <= ROI_Y_RST;
        end else if (vsyncRise) begin
            roiXAct <= roiXSh;
            roiYAct <= roiYSh;
        end
    end

    // Pending flag: a same-cycle write outranks the frame-start clear.
    always_ff @(posedge pixelClock or negedge reset) begin
        if (!reset)
            cfgPending <= 1'b0;
        else if (cfgAccept)
            cfgPending <= 1'b1;
        else if (vsyncRise)
            cfgPending <= 1'b0;
    end

    // Stage-1 ROI test and final mask selection.
    always_comb begin
        xIn      = (16'(xS1) >= roiXAct.start) && (16'(xS1) <= roiXAct.stop);
        yIn      = (16'(yS1) >= roiYAct.start) && (16'(yS1) <= roiYAct.stop);
        pixelOk  = pvS1 & frameSeen & ~outS1 & xIn & yIn;
        maskNext = '0;
        if (pixelOk)
            maskNext = bandHit;
    end

    // Stage 2: aligned output register set.
    always_ff @(posedge pixelClock or negedge reset) begin
        if (!reset) begin
            binMask  <= '0;
            hrefBin  <= 1'b0;
            vsyncBin <= 1'b0;
            pixelX   <= '0;
            pixelY   <= '0;
        end else begin
            binMask  <= maskNext;
            hrefBin  <= hrefS1;
            vsyncBin <= vsyncS1;
            pixelX   <= xS1;
            pixelY   <= yS1;
        end
    end

    // Count including the mask bit currently on the output, saturating.
    always_comb begin
        onesNext = onesCount;
        if (binMask[0] && onesCount != '1)
            onesNext = onesCount + NUM_BITS_S'(1);
    end

    // Publish as vsyncBin drops, folding in the last mask bit of the frame.
    assign statsFire = vsyncBin & ~vsyncS1;

    // Running per-frame count of binMask[0] ones.
    always_ff @(posedge pixelClock or negedge reset) begin
        if (!reset)
            onesCount <= '0;
        else if (vsyncRise)
            onesCount <= '0;
        else
            onesCount <= onesNext;
    end

    // Frame-end snapshot and its one-cycle strobe.
    always_ff @(posedge pixelClock or negedge reset) begin
        if (!reset) begin
            frameOnes       <= '0;
            frameStatsValid <= 1'b0;
        end else begin
            frameStatsValid <= statsFire;
            if (statsFire)
                frameOnes <= onesNext;
        end
    end

endmodule

// File: tb/tb_roi_threshold_binarizer.sv
// Directed bench for roi_threshold_binarizer at default parameters.
module tb_roi_threshold_binarizer;

    logic        pixelClock;
    logic        reset;
    logic        href;
    logic        vsync;
    logic [7:0]  camData;
    logic        cfgWrite;
    logic [3:0]  cfgAddr;
    logic [31:0] cfgData;
    logic        cfgPending;
    logic        hrefBin;
    logic        vsyncBin;
    logic [1:0]  binMask;
    logic [10:0] pixelX;
    logic [9:0]  pixelY;
    logic [20:0] frameOnes;
    logic        frameStatsValid;

    roi_threshold_binarizer dut (
        .pixelClock     (pixelClock),
        .reset          (reset),
        .href           (href),
        .vsync          (vsync),
        .camData        (camData),
        .cfgWrite       (cfgWrite),
        .cfgAddr        (cfgAddr),
        .cfgData        (cfgData),
        .cfgPending     (cfgPending),
        .hrefBin        (hrefBin),
        .vsyncBin       (vsyncBin),
        .binMask        (binMask),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .frameOnes      (frameOnes),
        .frameStatsValid(frameStatsValid)
    );

    initial pixelClock = 1'b0;
    always #5 pixelClock = ~pixelClock;

    typedef struct {
        int         x;
        int         y;
        logic [1:0] m;
        int         c;
    } rec_t;

    rec_t q[$];
    int   inCyc[$];
    int   cycNum = 0;
    int   statsCnt = 0;
    int   statsCyc = 0;
    int   vsFallCyc = 0;
    int   lastOnes = 0;
    logic statsAligned = 1'b0;
    logic prevVs = 1'b0;
    logic prevVsBin = 1'b0;

    int total = 0;
    int bad = 0;
    int bq, bi, bs;
    int e2 [8] = '{0, 2, 2, 0, 1, 1, 1, 1};

    always @(posedge pixelClock) cycNum++;

    // Output recorder, sampled on the inactive edge.
    always @(negedge pixelClock) begin
        rec_t r;
        if (href && vsync)
            inCyc.push_back(cycNum);
        if (prevVs && !vsync)
            vsFallCyc = cycNum;
        prevVs = vsync;
        if (hrefBin && vsyncBin) begin
            r.x = int'(pixelX);
            r.y = int'(pixelY);
            r.m = binMask;
            r.c = cycNum;
            q.push_back(r);
        end
        if (frameStatsValid) begin
            statsCnt++;
            statsCyc     = cycNum;
            lastOnes     = int'(frameOnes);
            statsAligned = prevVsBin && !vsyncBin;
        end
        prevVsBin = vsyncBin;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sumBits(input int from, input int n, input int msk);
        int s = 0;
        for (int i = 0; i < n; i++)
            if ((int'(q[from + i].m) & msk) != 0)
                s++;
        return s;
    endfunction

    task automatic tick();
        @(posedge pixelClock);
        #1;
    endtask

    task automatic idle(input int n);
        href    = 1'b0;
        camData = 8'd0;
        repeat (n) tick();
    endtask

    task automatic sendLine(input int n, input int a, input int b, input int c, input int d);
        for (int i = 0; i < n; i++) begin
            href    = 1'b1;
            camData = 8'((i == 0) ? a : (i == 1) ? b : (i == 2) ? c : d);
            tick();
        end
        idle(3);
    endtask

    task automatic cfg(input int a, input logic [31:0] d);
        cfgWrite = 1'b1;
        cfgAddr  = 4'(a);
        cfgData  = d;
        tick();
        cfgWrite = 1'b0;
    endtask

    task automatic frameStart();
        vsync = 1'b1;
        idle(2);
    endtask

    task automatic frameStartWrite(input int a, input logic [31:0] d);
        vsync = 1'b1;
        cfg(a, d);
        idle(2);
    endtask

    task automatic frameEnd();
        vsync = 1'b0;
        idle(6);
    endtask

    task automatic mark();
        bq = q.size();
        bi = inCyc.size();
        bs = statsCnt;
    endtask

    initial begin
        reset = 1'b0; href = 1'b0; vsync = 1'b0; camData = 8'd0;
        cfgWrite = 1'b0; cfgAddr = 4'd0; cfgData = 32'd0;
        repeat (3) tick();
        chk("rst_mask", binMask, 0);
        chk("rst_pending", cfgPending, 0);
        chk("rst_ones", frameOnes, 0);
        chk("rst_valid", frameStatsValid, 0);
        chk("rst_x", pixelX, 0);
        reset = 1'b1;
        idle(4);

        // Default bands pass only 255
        mark();
        frameStart();
        sendLine(4, 255, 254, 255, 0);
        sendLine(4, 255, 254, 255, 0);
        frameEnd();
        chk("t1_count", q.size() - bq, 8);
        for (int i = 0; i < 8; i++)
            chk("t1_mask", q[bq + i].m, (i % 2 == 0) ? 3 : 0);
        chk("t1_x3", q[bq + 3].x, 3);
        chk("t1_y4", q[bq + 4].y, 1);
        chk("t1_latency", q[bq].c - inCyc[bi], 2);
        chk("t1_ones", lastOnes, 4);
        chk("t1_pulses", statsCnt - bs, 1);
        chk("t1_aligned", statsAligned, 1);
        chk("t1_statlat", statsCyc - vsFallCyc, 2);

        // Band 1 = 100..150
        cfg(1, {16'd150, 16'd100});
        chk("t2_pend_set", cfgPending, 1);
        mark();
        frameStart();
        chk("t2_pend_clr", cfgPending, 0);
        sendLine(4, 99, 100, 150, 151);
        sendLine(4, 255, 255, 255, 255);
        frameEnd();
        for (int i = 0; i < 8; i++)
            chk("t2_mask", q[bq + i].m, e2[i]);
        chk("t2_ones", lastOnes, 4);

        // ROI x 1..2, y 1..1
        cfg(8, {16'd2, 16'd1});
        cfg(9, {16'd1, 16'd1});
        mark();
        frameStart();
        sendLine(4, 255, 255, 255, 255);
        sendLine(4, 255, 255, 255, 255);
        sendLine(4, 255, 255, 255, 255);
        frameEnd();
        chk("t3_count", q.size() - bq, 12);
        chk("t3_sum", sumBits(bq, 12, 1), 2);
        chk("t3_m5", q[bq + 5].m, 1);
        chk("t3_x5", q[bq + 5].x, 1);
        chk("t3_y5", q[bq + 5].y, 1);
        chk("t3_m6", q[bq + 6].m, 1);
        chk("t3_m1", q[bq + 1].m, 0);
        chk("t3_m9", q[bq + 9].m, 0);
        chk("t3_ones", lastOnes, 2);
        cfg(8, {16'd1279, 16'd0});
        cfg(9, {16'd799, 16'd0});

        // Mid-frame band 0 write waits for the next frame
        mark();
        frameStart();
        sendLine(4, 255, 10, 20, 255);
        cfg(0, {16'd20, 16'd10});
        chk("t4_pend_mid", cfgPending, 1);
        sendLine(4, 255, 10, 20, 255);
        frameEnd();
        chk("t4_old_m4", q[bq + 4].m, 1);
        chk("t4_old_m5", q[bq + 5].m, 0);
        chk("t4_old_ones", lastOnes, 4);
        mark();
        frameStart();
        chk("t4_pend_clr", cfgPending, 0);
        sendLine(4, 255, 10, 20, 21);
        frameEnd();
        chk("t4_new_m0", q[bq].m, 0);
        chk("t4_new_m1", q[bq + 1].m, 1);
        chk("t4_new_m2", q[bq + 2].m, 1);
        chk("t4_new_ones", lastOnes, 2);

        // Write coincident with frame start: inverted band 0 one frame later
        mark();
        frameStartWrite(0, {16'd100, 16'd200});
        chk("t5_pend_hold", cfgPending, 1);
        sendLine(4, 10, 20, 200, 100);
        frameEnd();
        chk("t5_m0", q[bq].m, 1);
        chk("t5_m3", q[bq + 3].m, 2);
        chk("t5_ones", lastOnes, 2);
        mark();
        frameStart();
        chk("t5_pend_clr", cfgPending, 0);
        sendLine(4, 100, 150, 200, 255);
        frameEnd();
        chk("t5_inv_sum", sumBits(bq, 4, 1), 0);
        chk("t5_inv_m0", q[bq].m, 2);
        chk("t5_inv_ones", lastOnes, 0);

        // Empty ROI (x start > end)
        cfg(8, {16'd0, 16'd5});
        mark();
        frameStart();
        sendLine(4, 100, 100, 100, 100);
        frameEnd();
        chk("t6_count", q.size() - bq, 4);
        chk("t6_sum", sumBits(bq, 4, 3), 0);
        cfg(8, {16'd1279, 16'd0});
        cfg(0, {16'd255, 16'd0});

        // 1300-pixel line saturates X at 1279
        mark();
        frameStart();
        sendLine(1300, 255, 255, 255, 255);
        frameEnd();
        chk("t7_count", q.size() - bq, 1300);
        chk("t7_m1278", q[bq + 1278].m, 1);
        chk("t7_m1279", q[bq + 1279].m, 0);
        chk("t7_x1299", q[bq + 1299].x, 1279);
        chk("t7_m1299", q[bq + 1299].m, 0);
        chk("t7_sum", sumBits(bq, 1300, 1), 1279);
        chk("t7_ones", lastOnes, 1279);

        // Reset mid-line
        frameStart();
        for (int i = 0; i < 4; i++) begin
            href    = 1'b1;
            camData = 8'd255;
            tick();
        end
        chk("t8_pre_mask", binMask, 1);
        reset = 1'b0;
        #1;
        chk("t8_mask", binMask, 0);
        chk("t8_href", hrefBin, 0);
        chk("t8_vsync", vsyncBin, 0);
        chk("t8_x", pixelX, 0);
        chk("t8_ones", frameOnes, 0);
        chk("t8_pend", cfgPending, 0);
        tick();
        tick();
        reset = 1'b1;
        mark();
        for (int i = 0; i < 4; i++) begin
            href    = 1'b1;
            camData = 8'd255;
            tick();
        end
        idle(3);
        sendLine(4, 255, 255, 255, 255);
        frameEnd();
        chk("t8_post_count", q.size() - bq, 8);
        chk("t8_post_sum", sumBits(bq, 8, 3), 0);
        chk("t8_post_ones", lastOnes, 0);
        mark();
        frameStart();
        sendLine(4, 255, 254, 255, 0);
        frameEnd();
        chk("t8_next_m0", q[bq].m, 3);
        chk("t8_next_m1", q[bq + 1].m, 0);
        chk("t8_next_m2", q[bq + 2].m, 3);
        chk("t8_next_ones", lastOnes, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/roi_threshold_binarizer.md
# roi_threshold_binarizer

Parametrised successor to the single-threshold camera binarizer in the mocap front end. It sits in the pixelClock domain between the camera input and connected-component labelling. Per pixel it produces a NUM_CHANNELS-bit mask: bit c is set when the pixel lies inside band threshold c and inside a rectangular region of interest. Configuration is double-buffered and takes effect only at frame start. Per-frame marker-pixel statistics are reported at frame end.

## Interface
- DATA_WIDTH, 8: pixel width, 1..16.
- NUM_CHANNELS, 2: independent threshold bands, 1..8.
- IMAGE_WIDTH, 1280: maximum pixels per line.
- IMAGE_HEIGHT, 800: maximum lines per frame.
- NUM_BITS_X / NUM_BITS_Y, $clog2(IMAGE_WIDTH) / $clog2(IMAGE_HEIGHT): derived; must not be overridden.

Ports (name, direction, width, meaning):
- pixelClock  in  1  the only clock.
- reset  in  1  asynchronous, active-low.
- href  in  1  line valid.
- vsync  in  1  low active: low = vertical blanking, high = frame active.
- camData  in  DATA_WIDTH  pixel value.
- cfgWrite  in  1  one-cycle write strobe to the shadow registers.
- cfgAddr  in  4  register address: 0..NUM_CHANNELS-1 = band c; 8 = ROI x; 9 = ROI y.
- cfgData  in  32  band: low = [DATA_WIDTH-1:0], high = [16+DATA_WIDTH-1:16]. ROI: start = [15:0], end = [31:16], inclusive.
- cfgPending  out  1  shadow differs from active, awaiting frame start.
- hrefBin / vsyncBin  out  1 each  href/vsync delayed to align with binMask.
- binMask  out  NUM_CHANNELS  per-channel binary pixel.
- pixelX / pixelY  out  NUM_BITS_X / NUM_BITS_Y  coordinates of the current output pixel.
- frameOnes  out  NUM_BITS_X+NUM_BITS_Y  count of binMask[0] ones in the last frame.
- frameStatsValid  out  1  one-cycle pulse when frameOnes updates.

## Operation
- Pixel valid: pv = href & vsync.
- X counter:
  - Increments on each pv cycle.
  - Clears on the href falling edge.
  - Saturates at IMAGE_WIDTH-1; pixels beyond saturation are treated as outside the ROI.
- Y counter:
  - Increments on the href falling edge while vsync = 1.
  - Clears while vsync = 0.
  - Saturates at IMAGE_HEIGHT-1.
- Mask rule: binMask[c] = pv & inRoi & (low_c <= camData <= high_c), all comparisons unsigned. If low_c > high_c, channel c never fires.
- inRoi: x0 <= X <= x1 and y0 <= Y <= y1, inclusive. If start > end on an axis, the ROI is empty and all masks are 0.
- Shadow registers:
  - cfgWrite to an unused address (NUM_CHANNELS..7, 10..15) is ignored.
  - A write sets cfgPending.
  - On the vsync rising edge (frame start), every shadow register copies to its active register at once, and cfgPending clears.
  - A write in the same cycle as the vsync rising edge is kept in the shadow, applies at the next frame start, and cfgPending stays 1.
- Statistics:
  - A counter counts binMask[0] ones.
  - It saturates at all-ones.
  - It clears at frame start.
  - On the vsync falling edge it is copied to frameOnes, with frameStatsValid pulsed.
- Reset values:
  - All outputs 0, counters 0, cfgPending 0.
  - Every band, shadow and active: low = high = all-ones, so only saturated pixels pass.
  - ROI: x 0..IMAGE_WIDTH-1, y 0..IMAGE_HEIGHT-1.

## Timing
- Two-stage pipeline:
  - Stage 1 registers camData, href, vsync and the X/Y counters.
  - Stage 2 registers the comparisons, binMask, hrefBin, vsyncBin, pixelX and pixelY.
  - Output for an input at cycle n appears at cycle n+2.
- Edge detectors act on the stage-1 copies of href and vsync.
- Configuration:
  - Active thresholds change at the stage-1 vsync rising edge, before the first pixel of the frame reaches stage 2.
  - A frame is never binarized with mixed configuration.
- frameStatsValid asserts on the cycle vsyncBin falls, i.e. two cycles after the input vsync falls.
- Asynchronous reset mid-frame:
  - Everything returns to reset values immediately.
  - After release, no mask bit is produced until the next vsync rising edge, via a frameSeen flag cleared by reset.

## Test plan
- Default config, 4x2 frame, pixels 255,254,255,0 -> binMask[0] = 1,0,1,0 at 2-cycle latency; frameOnes = 4 on the vsync fall; frameStatsValid high for 1 cycle.
- Band 1 = {low 100, high 150}, pixels 99,100,150,151 -> binMask[1] = 0,1,1,0; binMask[0] unchanged.
- ROI x = 1..2, y = 1..1 on a 4x3 all-255 frame -> ones only at (1,1) and (2,1); frameOnes = 2.
- Write band 0 mid-frame -> cfgPending = 1; current frame uses the old band; next frame uses the new band; cfgPending clears at the vsync rise. Write coincident with the vsync rise -> applies one frame later.
- low = 200, high = 100 -> channel stays 0 for the whole frame. ROI start > end -> all zero. Line of 1300 pixels with IMAGE_WIDTH = 1280 -> pixelX holds 1279; last 21 pixels masked.
- Assert reset mid-line -> all outputs 0 within the same cycle; no mask bits until the next frame start; then normal operation.
